// File: rtl/risc_fetch_queue.sv
// risc_fetch_queue
// ----------------
// Instruction prefetch queue between fetch and decode/operand-fetch.
// Buffers fetched instruction words together with their PC+1 values, so
// fetch keeps running while decode stalls. A branch/jump flush drops every
// buffered word. Decode sees either a valid head entry or an all-zero NOP
// with out_valid low.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   When defined, a word arriving at an empty queue is presented on out_*
//   in the same cycle. If decode takes it, the word is never written.
//
// Ports:
//   CLK        in   clock, all state changes on rising edge
//   reset      in   synchronous active-low reset
//   in_valid   in   fetch presents a word
//   in_ready   out  queue accepts a word this cycle
//   in_pc_1    in   PC+1 of the fetched word
//   in_ir      in   fetched instruction
//   flush      in   discard all queued words
//   out_valid  out  head entry valid for decode
//   out_ready  in   decode consumes head this cycle
//   out_pc_1   out  head PC+1, zero when out_valid is low
//   out_ir     out  head instruction, zero (NOP) when out_valid is low
//   count      out  occupied entries
//   flush_cnt  out  saturating count of flushes that discarded entries
module risc_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8,
  parameter int IR_W  = 32
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc_1,
  input  logic [IR_W-1:0]          in_ir,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc_1,
  output logic [IR_W-1:0]          out_ir,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               flush_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PC_W-1:0] pc_mem_r [DEPTH];
  logic [IR_W-1:0] ir_mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [7:0]      flush_cnt_r;

  logic            empty_s;
  logic            bypass_s;
  logic            in_ready_s;
  logic            out_valid_s;
  logic            push_s;
  logic            pop_s;
  logic [PC_W-1:0] out_pc_1_s;
  logic [IR_W-1:0] out_ir_s;

  assign empty_s = (count_r == {CW{1'b0}});

`ifdef FETCH_QUEUE_BYPASS_EN
  // Hand an incoming word straight to decode while the queue is empty.
  assign bypass_s = empty_s & in_valid & ~flush & reset;
`else
  assign bypass_s = 1'b0;
`endif

  // in_ready looks only at count and flush, so a full queue never accepts a
  // word even when a pop happens in the same cycle.
  assign in_ready_s  = (count_r != FULL_COUNT) & ~flush;
  assign out_valid_s = (~empty_s | bypass_s) & ~flush;

  // A bypassed word that decode takes is neither written nor popped.
  assign push_s = in_valid & in_ready_s & ~(bypass_s & out_ready);
  assign pop_s  = out_valid_s & out_ready & ~bypass_s;

  // Head selection with NOP masking when nothing is valid.
  always_comb begin
    out_pc_1_s = {PC_W{1'b0}};
    out_ir_s   = {IR_W{1'b0}};
    if (!out_valid_s) begin
      out_pc_1_s = {PC_W{1'b0}};
      out_ir_s   = {IR_W{1'b0}};
    end else if (bypass_s) begin
      out_pc_1_s = in_pc_1;
      out_ir_s   = in_ir;
    end else begin
      out_pc_1_s = pc_mem_r[rd_ptr_r];
      out_ir_s   = ir_mem_r[rd_ptr_r];
    end
  end

  // Entry storage; never cleared, only pointers and count are.
  always_ff @(posedge CLK) begin
    if (push_s && reset && !flush) begin
      pc_mem_r[wr_ptr_r] <= in_pc_1;
      ir_mem_r[wr_ptr_r] <= in_ir;
    end
  end

  // Pointers, occupancy and flush statistics; reset beats flush beats push/pop.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      flush_cnt_r <= 8'd0;
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      if (!empty_s && (flush_cnt_r != 8'hFF)) begin
        flush_cnt_r <= flush_cnt_r + 8'd1;
      end
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_pc_1  = out_pc_1_s;
  assign out_ir    = out_ir_s;
  assign count     = count_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_risc_fetch_queue.sv
// Self-checking bench for risc_fetch_queue. A queue-based reference model
// predicts the visible outputs each cycle; inputs change just after the
// rising edge and outputs are sampled on the falling edge.
module tb_risc_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic        in_ready, out_valid;
  logic [7:0]  in_pc_1, out_pc_1, flush_cnt;
  logic [31:0] in_ir, out_ir;
  logic [CW-1:0] count;

  risc_fetch_queue #(.DEPTH(DEPTH), .PC_W(8), .IR_W(32)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_1(in_pc_1), .in_ir(in_ir), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc_1(out_pc_1), .out_ir(out_ir),
    .count(count), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [7:0] pc; logic [31:0] ir; } ent_t;

  ent_t q[$];
  int   fcnt = 0;
  int   total = 0;
  int   bad = 0;

  // Pending cycle inputs / predictions used by the model at the edge.
  bit   p_rst, p_iv, p_fl, p_ordy, p_byp, p_ov, p_irdy;
  ent_t p_ent;

  wire  [52:0] obs_vec = {out_valid, in_ready, out_pc_1, out_ir, count, flush_cnt};
  logic [52:0] exp_vec;

  // Apply one cycle of inputs and predict the combinational outputs.
  task automatic drive(input bit r, input bit iv, input logic [7:0] pc,
                       input logic [31:0] ir, input bit fl, input bit ordy);
    ent_t head;
    reset = r; in_valid = iv; in_pc_1 = pc; in_ir = ir; flush = fl; out_ready = ordy;
    p_rst = r; p_iv = iv; p_fl = fl; p_ordy = ordy; p_ent = {pc, ir};
    p_byp  = BYP && r && (q.size() == 0) && iv && !fl;
    p_irdy = (q.size() < DEPTH) && !fl;
    p_ov   = !fl && ((q.size() > 0) || p_byp);
    if (!p_ov) head = '0;
    else if (p_byp) head = p_ent;
    else head = q[0];
    exp_vec = {p_ov, p_irdy, head.pc, head.ir, CW'(q.size()), 8'(fcnt)};
  endtask

  // Advance past the rising edge and update the reference model.
  task automatic advance();
    bit pop, push;
    @(posedge CLK);
    if (!p_rst) begin
      q.delete(); fcnt = 0;
    end else if (p_fl) begin
      if (q.size() > 0 && fcnt < 255) fcnt++;
      q.delete();
    end else begin
      pop  = p_ov && p_ordy;
      push = p_iv && p_irdy;
      if (!(p_byp && pop)) begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(p_ent);
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) begin
      drive(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
      @(negedge CLK);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL drain cyc=%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 8'hAA, 32'hDEADBEEF, 1'b0, 1'b0);
    advance();
    drive(1'b0, 1'b1, 8'hAA, 32'hDEADBEEF, 1'b0, 1'b0);
    @(negedge CLK);
    total++;
    if (obs_vec !== exp_vec) begin
      bad++; $display("FAIL reset_hold got=%h want=%h", obs_vec, exp_vec);
    end
    total++;
    if ({out_valid, out_ir, count, flush_cnt} !== {1'b0, 32'h0, 3'd0, 8'd0}) begin
      bad++; $display("FAIL reset_const ov=%b ir=%h cnt=%0d fc=%0d want 0/0/0/0",
                      out_valid, out_ir, count, flush_cnt);
    end
    advance();
    drive(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    @(negedge CLK);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release in_ready got=%b want=1", in_ready);
    end
    advance();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1, 8'(i), $urandom, 1'b0, 1'b0);
      @(negedge CLK);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL fill cyc=%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
    total++;
    if ({count, in_ready} !== {3'd4, 1'b0}) begin
      bad++; $display("FAIL full count=%0d in_ready=%b want 4/0", count, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
      @(negedge CLK);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL drain_order cyc=%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
      total++;
      if (i < 4 && out_pc_1 !== 8'(i + 1)) begin
        bad++; $display("FAIL drain_pc cyc=%0d got=%h want=%h", i, out_pc_1, 8'(i + 1));
      end
      advance();
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 8'(i + 16), 32'h1000 + 32'(i), 1'b0, 1'b1);
      @(negedge CLK);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL stream cyc=%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
    total++;
    if (count !== (BYP ? 3'd0 : 3'd1)) begin
      bad++; $display("FAIL stream_count got=%0d want=%0d", count, BYP ? 0 : 1);
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      // three pushes, flush with a word offered, then a flush while empty
      if (i < 3) drive(1'b1, 1'b1, 8'(i + 64), $urandom, 1'b0, 1'b0);
      else if (i == 3) drive(1'b1, 1'b1, 8'hEE, 32'hEEEE_EEEE, 1'b1, 1'b1);
      else drive(1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
      @(negedge CLK);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL flush cyc=%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
    drive(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
    @(negedge CLK);
    total++;
    if ({count, flush_cnt, out_valid} !== {3'd0, 8'd1, 1'b0}) begin
      bad++; $display("FAIL flush_after cnt=%0d fc=%0d ov=%b want 0/1/0",
                      count, flush_cnt, out_valid);
    end
    advance();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 2; k++) begin
        drive(1'b1, k == 0, 8'(i), $urandom, k == 1, 1'b0);
        @(negedge CLK);
        total++;
        if (obs_vec !== exp_vec) begin
          bad++; $display("FAIL sat it=%0d ph=%0d got=%h want=%h", i, k, obs_vec, exp_vec);
        end
        advance();
      end
    end
    drive(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    @(negedge CLK);
    total++;
    if (flush_cnt !== 8'd255) begin
      bad++; $display("FAIL sat_final got=%0d want=255", flush_cnt);
    end
    advance();
  endtask

  task automatic test_bypass();
    drain();
    drive(1'b1, 1'b1, 8'h5A, 32'h12345678, 1'b0, 1'b1);
    @(negedge CLK);
    total++;
    if (obs_vec !== exp_vec) begin
      bad++; $display("FAIL bypass_cyc0 got=%h want=%h", obs_vec, exp_vec);
    end
    total++;
    if (out_valid !== BYP || out_ir !== (BYP ? 32'h12345678 : 32'h0)) begin
      bad++; $display("FAIL bypass_same ov=%b ir=%h want ov=%b", out_valid, out_ir, BYP);
    end
    advance();
    drive(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    @(negedge CLK);
    total++;
    if ({out_valid, count} !== (BYP ? {1'b0, 3'd0} : {1'b1, 3'd1})) begin
      bad++; $display("FAIL bypass_next ov=%b cnt=%0d", out_valid, count);
    end
    advance();
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 8'($urandom),
            $urandom, $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0);
      @(negedge CLK);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stream();
    test_flush();
    test_saturation();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/risc_fetch_queue.md
# risc_fetch_queue

Instruction prefetch queue between the instruction-fetch stage and the decode/operand-fetch stage of the pipelined RISC core. It buffers fetched instruction words with their PC+1 values, so fetch keeps running while decode stalls. It drops all buffered words on a branch/jump flush. Decode always sees either a valid instruction or an all-zero NOP with `out_valid` low.

## Interface
Parameters:
- `DEPTH`, 4: entries; power of two, 2..16
- `PC_W`, 8: PC width
- `IR_W`, 32: instruction width

Ports:
- `CLK` in 1: single clock; all state changes on rising edge
- `reset` in 1: synchronous, active-low reset; sampled on `CLK` rising edge
- `in_valid` in 1: fetch presents a word
- `in_ready` out 1: queue accepts a word this cycle
- `in_pc_1` in PC_W: PC+1 of the fetched word
- `in_ir` in IR_W: fetched instruction
- `flush` in 1: branch taken or mispredicted; discard contents
- `out_valid` out 1: head entry valid for decode
- `out_ready` in 1: decode consumes head this cycle
- `out_pc_1` out PC_W: head PC+1; 0 when `out_valid`=0
- `out_ir` out IR_W: head instruction; 0 (NOP) when `out_valid`=0
- `count` out clog2(DEPTH)+1: occupied entries
- `flush_cnt` out 8: saturating count of flushes that discarded at least one entry

## Operation
- Circular buffer with `wr_ptr` and `rd_ptr`, each clog2(DEPTH) bits, wrapping modulo DEPTH.
- `count` is held in a register; it is not derived from the pointers.
- Push when `in_valid & in_ready`. Pop when `out_valid & out_ready`.
- `in_ready` = (`count` < DEPTH) & ~`flush`. It depends only on `count` and `flush`, never on `out_ready`, so there is no push-when-full even if a pop occurs in the same cycle.
- `out_valid` = (`count` != 0) & ~`flush`.
- Push and pop in the same cycle: both pointers advance and `count` is unchanged.
- Flush takes priority over push and pop:
  - In the flush cycle, no push and no pop occur.
  - Next cycle: `count`=0 and `wr_ptr`=`rd_ptr`=0.
  - If `count` was nonzero at the flush edge, `flush_cnt` increments, saturating at 255.
- A flush while empty does not change `flush_cnt`.
- Storage contents are not cleared by reset or flush; only the pointers and `count` are.
- Reset (`reset`=0 at an edge) overrides everything, including an active flush. After the edge:
  - `count`=0, pointers=0, `flush_cnt`=0
  - `out_valid`=0, `out_pc_1`=0, `out_ir`=0
  - `in_ready`=1 once `reset` is released
- Reset asserted mid-stream loses all queued entries. The first push after release is the new head.

## Timing
- Without bypass, minimum latency is 1 cycle: a word pushed at edge N is visible on `out_*` after edge N and can be popped at edge N+1.
- `out_pc_1` and `out_ir` are read combinationally from the head entry and masked to 0 when `out_valid`=0. There is no extra output register.
- `flush` masks `in_ready` and `out_valid` combinationally in the same cycle. The internal clear happens at the edge.
- Throughput is 1 word per cycle in steady state whenever `count` is strictly between 0 and DEPTH.
- When full, `in_ready` is 0. It returns to 1 the cycle after a pop.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When `count`=0, `in_valid`=1 and `flush`=0, the input word drives `out_*` combinationally and `out_valid`=1.
  - If `out_ready`=1 in that cycle, the word is consumed and never written; pointers and `count` stay unchanged.
  - If `out_ready`=0, the word is written normally.
- Undefined: no bypass path. `out_valid` comes only from stored entries, giving 1-cycle minimum latency.

## Test plan
- **Reset:** hold `reset`=0 for 2 edges with `in_valid`=1 and `in_ir`=32'hDEADBEEF -> `count`=0, `out_valid`=0, `out_ir`=0, `flush_cnt`=0; after release, `in_ready`=1.
- **Fill and drain:** `out_ready`=0; push 4 words with `in_pc_1` 8'h01..8'h04 -> `count`=4, `in_ready`=0, a 5th push is ignored. Then `out_ready`=1 -> words pop in order 01,02,03,04; `count` returns to 0.
- **Streaming and wrap:** `in_valid`=`out_ready`=1 for 20 cycles with incrementing IR -> output sequence is identical with no gaps after the first cycle. Pointers wrap 5 times; `count` stays 1 without bypass, 0 with bypass.
- **Flush:** with 3 entries queued, assert `flush` for 1 cycle while `in_valid`=1 -> `out_valid`=0 and `in_ready`=0 in that cycle, `count`=0 next cycle, `flush_cnt`=1. The flush-cycle word is absent from the output. A second flush while empty leaves `flush_cnt`=1.
- **Saturation:** perform 300 flushes, each with 1 entry queued -> `flush_cnt`=255.
- **Bypass (`FETCH_QUEUE_BYPASS_EN`):** empty queue, `in_valid`=`out_ready`=1, `in_ir`=32'h12345678 -> `out_ir`=32'h12345678 and `out_valid`=1 in the same cycle, and `count` stays 0. Without the macro: `out_valid`=0 that cycle and 1 the next.
